// File: rtl/baud_pkg.sv
// Shared baud-rate definitions: minimum divisor, 12 MHz divisor table and a
// helper that splits clk/baud into integer and fractional divisor parts.
package baud_pkg;

    // Smallest usable divisor; keeps P/4 >= 1 so every phase output exists.
    localparam int DIV_MIN = 4;

    // Fractional width the helper function produces.
    localparam int BAUD_FRAC_W = 4;

    // Integer divisors for a 12 MHz system clock.
    localparam int DIV_12M_600K  = 20;
    localparam int DIV_12M_300K  = 40;
    localparam int DIV_12M_150K  = 80;
    localparam int DIV_12M_115K2 = 104;
    localparam int DIV_12M_57K6  = 208;
    localparam int DIV_12M_38K4  = 313;
    localparam int DIV_12M_19K2  = 625;
    localparam int DIV_12M_9K6   = 1250;
    localparam int DIV_12M_4K8   = 2500;
    localparam int DIV_12M_2K4   = 5000;
    localparam int DIV_12M_1K2   = 10000;
    localparam int DIV_12M_1K    = 12000;
    localparam int DIV_12M_600   = 20000;
    localparam int DIV_12M_300   = 40000;
    localparam int DIV_12M_50    = 240000;
    localparam int DIV_12M_5     = 2400000;

    // Integer and fractional divisor pair.
    typedef struct packed {
        logic [31:0]            div_int;
        logic [BAUD_FRAC_W-1:0] div_frac;
    } baud_div_t;

    // Split clk_hz/baud into integer part and truncated fraction in 1/2^BAUD_FRAC_W units.
    function automatic baud_div_t baud_div(input longint unsigned clk_hz,
                                           input longint unsigned baud);
        baud_div_t       res;
        longint unsigned rem;
        res.div_int  = 32'd0;
        res.div_frac = {BAUD_FRAC_W{1'b0}};
        rem          = 64'd0;
        if (baud == 64'd0) begin
            res.div_int  = 32'd0;
            res.div_frac = {BAUD_FRAC_W{1'b0}};
        end else begin
            res.div_int  = 32'(clk_hz / baud);
            rem          = clk_hz % baud;
            res.div_frac = BAUD_FRAC_W'((rem << BAUD_FRAC_W) / baud);
        end
        return res;
    endfunction

endpackage

// File: rtl/baud_phase_decode.sv
// Decodes the period counter into the period tick, midpoint strobe and the
// half/quarter phase levels. Purely combinational; all outputs are 0 when
// the generator is disabled.
module baud_phase_decode import baud_pkg::*; #(
    parameter int DIV_W = 24
) (
    input  logic [DIV_W-1:0] cnt,
    input  logic [DIV_W:0]   period,
    input  logic             enable,
    output logic             clk_out,
    output logic             mid_strobe,
    output logic             half_clk_out,
    output logic             quarter_clk_out
);

    // Compare in DIV_W+1 bits: period can reach 2^DIV_W when the dither adds a clock.
    logic [DIV_W:0] cnt_x_s;
    logic [DIV_W:0] half_s;
    logic [DIV_W:0] quarter_s;
    logic [DIV_W:0] three_q_s;
    logic [DIV_W:0] last_s;

    assign cnt_x_s   = {1'b0, cnt};
    assign half_s    = period >> 1;
    assign quarter_s = period >> 2;
    assign three_q_s = half_s + quarter_s;
    assign last_s    = period - {{DIV_W{1'b0}}, 1'b1};

    // Phase decode from counter position within the current period.
    always_comb begin
        clk_out         = 1'b0;
        mid_strobe      = 1'b0;
        half_clk_out    = 1'b0;
        quarter_clk_out = 1'b0;
        if (enable) begin
            clk_out         = (cnt_x_s == last_s);
            mid_strobe      = (cnt_x_s == half_s);
            half_clk_out    = (cnt_x_s >= half_s);
            quarter_clk_out = ((cnt_x_s >= quarter_s) && (cnt_x_s < half_s)) ||
                              (cnt_x_s >= three_q_s);
        end else begin
            clk_out         = 1'b0;
            mid_strobe      = 1'b0;
            half_clk_out    = 1'b0;
            quarter_clk_out = 1'b0;
        end
    end

endmodule

// File: rtl/baudrate_frac.sv
// Runtime-programmable fractional baud generator. The average period is
// div + frac/2^FRAC_W clocks, realised by stretching individual periods by
// one clock whenever the phase accumulator carries. New divisors arrive via
// a load/ack handshake and only take effect at a period boundary (or
// immediately while disabled), so a running period is never cut short.
module baudrate_frac import baud_pkg::*; #(
    parameter int DIV_W        = 24,
    parameter int FRAC_W       = 4,
    parameter int DEFAULT_DIV  = 80,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [FRAC_W-1:0] frac_in,
    input  logic              load,
    output logic              load_ack,
    output logic              clk_out,
    output logic              half_clk_out,
    output logic              quarter_clk_out,
    output logic              mid_strobe
);

    logic [DIV_W-1:0]  cnt_r;
    logic [FRAC_W-1:0] acc_r;
    logic [DIV_W-1:0]  div_r;
    logic [FRAC_W-1:0] frac_r;
    logic [DIV_W-1:0]  pend_div_r;
    logic [FRAC_W-1:0] pend_frac_r;
    logic              pend_r;
    logic              ext_r;

    logic [DIV_W-1:0]  div_eff_s;
    logic [DIV_W:0]    period_s;
    logic [FRAC_W:0]   acc_sum_s;
    logic              boundary_s;
    logic              apply_s;

    // Clamp the active divisor so every quarter phase is at least one clock.
    always_comb begin
        div_eff_s = div_r;
        if (div_r < DIV_W'(DIV_MIN)) begin
            div_eff_s = DIV_W'(DIV_MIN);
        end else begin
            div_eff_s = div_r;
        end
    end

    assign period_s  = {1'b0, div_eff_s} + {{DIV_W{1'b0}}, ext_r};
    assign acc_sum_s = {1'b0, acc_r} + {1'b0, frac_r};

    // Pending values go live on a boundary, or at once while disabled; never during reset.
    assign apply_s  = pend_r & ~reset & (boundary_s | ~enable);
    assign load_ack = apply_s;
    assign clk_out  = boundary_s;

    baud_phase_decode #(
        .DIV_W (DIV_W)
    ) u_decode (
        .cnt             (cnt_r),
        .period          (period_s),
        .enable          (enable),
        .clk_out         (boundary_s),
        .mid_strobe      (mid_strobe),
        .half_clk_out    (half_clk_out),
        .quarter_clk_out (quarter_clk_out)
    );

    // Period counter, dither accumulator and active divisor registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_r  <= {DIV_W{1'b0}};
            acc_r  <= {FRAC_W{1'b0}};
            ext_r  <= 1'b0;
            div_r  <= DIV_W'(DEFAULT_DIV);
            frac_r <= FRAC_W'(DEFAULT_FRAC);
        end else begin
            if (!enable) begin
                cnt_r <= {DIV_W{1'b0}};
                acc_r <= {FRAC_W{1'b0}};
                ext_r <= 1'b0;
            end else if (boundary_s) begin
                cnt_r <= {DIV_W{1'b0}};
                acc_r <= acc_sum_s[FRAC_W-1:0];
                ext_r <= acc_sum_s[FRAC_W];
            end else begin
                cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end
            // A fresh divisor restarts the dither sequence from zero phase.
            if (apply_s) begin
                div_r  <= pend_div_r;
                frac_r <= pend_frac_r;
                acc_r  <= {FRAC_W{1'b0}};
                ext_r  <= 1'b0;
            end else begin
                div_r  <= div_r;
                frac_r <= frac_r;
            end
        end
    end

    // Single-entry pending slot: a newer load simply overwrites an unapplied one.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pend_div_r  <= {DIV_W{1'b0}};
            pend_frac_r <= {FRAC_W{1'b0}};
            pend_r      <= 1'b0;
        end else if (load) begin
            pend_div_r  <= div_in;
            pend_frac_r <= frac_in;
            pend_r      <= 1'b1;
        end else if (apply_s) begin
            pend_r      <= 1'b0;
        end else begin
            pend_r      <= pend_r;
        end
    end

endmodule

// File: tb/tb_baudrate_frac.sv
// Self-checking bench for baudrate_frac: scenario tasks plus randomized
// divisor/fraction runs compared against an arithmetic period model.
module tb_baudrate_frac;
    import baud_pkg::*;

    localparam int DIV_W  = 24;
    localparam int FRAC_W = 4;
    localparam int FSCALE = 16;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              enable;
    logic [DIV_W-1:0]  div_in;
    logic [FRAC_W-1:0] frac_in;
    logic              load;
    logic              load_ack;
    logic              clk_out;
    logic              half_clk_out;
    logic              quarter_clk_out;
    logic              mid_strobe;

    int checks   = 0;
    int failures = 0;

    baudrate_frac #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .DEFAULT_DIV  (80),
        .DEFAULT_FRAC (0)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .enable          (enable),
        .div_in          (div_in),
        .frac_in         (frac_in),
        .load            (load),
        .load_ack        (load_ack),
        .clk_out         (clk_out),
        .half_clk_out    (half_clk_out),
        .quarter_clk_out (quarter_clk_out),
        .mid_strobe      (mid_strobe)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int eff_div(input int d);
        return (d < 4) ? 4 : d;
    endfunction

    // Length of period k after the divisor went live: period k is one clock
    // longer when the running fraction sum k*f/16 crossed an integer.
    function automatic int period_len(input int d, input int f, input int k);
        if (k == 0) return eff_div(d);
        return eff_div(d) + ((k * f) / FSCALE) - (((k - 1) * f) / FSCALE);
    endfunction

    // Expected {clk_out, mid_strobe, half_clk_out, quarter_clk_out} at offset c.
    function automatic logic [3:0] model_out(input int p, input int c);
        logic [3:0] v;
        v[3] = (c == p - 1);
        v[2] = (c == p / 2);
        v[1] = (c >= p / 2);
        v[0] = ((c >= p / 4) && (c < p / 2)) || (c >= p / 2 + p / 4);
        return v;
    endfunction

    function automatic logic [4:0] observed();
        return {clk_out, mid_strobe, half_clk_out, quarter_clk_out, load_ack};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Load while disabled; reports load_ack in the load cycle and the one after.
    task automatic load_disabled(input int d, input int f,
                                 output logic ack_first, output logic ack_next);
        enable  = 1'b0;
        div_in  = DIV_W'(d);
        frac_in = FRAC_W'(f);
        load    = 1'b1;
        settle();
        ack_first = load_ack;
        step();
        load = 1'b0;
        settle();
        ack_next = load_ack;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [4:0] expv;
        baud_div_t  bd;
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        div_in = {DIV_W{1'b0}}; frac_in = {FRAC_W{1'b0}};
        step(); step();
        settle();
        checks++;
        if (observed() !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", observed(), 5'b00000);
        end
        reset = 1'b0; enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 80; c++) begin
                settle();
                expv = {model_out(80, c), 1'b0};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL default_period k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                step();
            end
        end
        bd = baud_div(64'd12000000, 64'd150000);
        checks++;
        if (bd.div_int !== 32'd80 || bd.div_frac !== 4'd0) begin
            failures++;
            $display("FAIL baud_div_150k got=%0d.%0d exp=80.0", bd.div_int, bd.div_frac);
        end
        bd = baud_div(64'd12000000, 64'd115200);
        checks++;
        if (bd.div_int !== 32'd104 || bd.div_frac !== 4'd2) begin
            failures++;
            $display("FAIL baud_div_115k2 got=%0d.%0d exp=104.2", bd.div_int, bd.div_frac);
        end
    endtask

    task automatic test_frac_dither();
        logic a0, a1;
        int total, longs, plen, nclk, guard;
        load_disabled(104, 3, a0, a1);
        checks++;
        if ({a0, a1} !== 2'b01) begin
            failures++;
            $display("FAIL frac_load_ack got=%b exp=01", {a0, a1});
        end
        enable = 1'b1;
        // Period 0 follows the apply and never carries an extra clock; skip it.
        guard = 0; nclk = 0;
        while (nclk < 1 && guard < 200) begin
            settle();
            if (clk_out) nclk++;
            step();
            guard++;
        end
        checks++;
        if (guard !== 104) begin
            failures++;
            $display("FAIL frac_first_period got=%0d exp=104", guard);
        end
        for (int blk = 0; blk < 2; blk++) begin
            total = 0; longs = 0; plen = 0; nclk = 0; guard = 0;
            while (nclk < 16 && guard < 2000) begin
                settle();
                plen++; total++;
                if (clk_out) begin
                    nclk++;
                    if (plen == 105) longs++;
                    plen = 0;
                end
                step();
                guard++;
            end
            checks++;
            if (nclk !== 16) begin
                failures++;
                $display("FAIL frac_timeout blk=%0d got=%0d periods exp=16", blk, nclk);
            end
            checks++;
            if (total !== 1667) begin
                failures++;
                $display("FAIL frac_total blk=%0d got=%0d exp=1667", blk, total);
            end
            checks++;
            if (longs !== 3) begin
                failures++;
                $display("FAIL frac_long_periods blk=%0d got=%0d exp=3", blk, longs);
            end
        end
    endtask

    task automatic test_mid_load();
        logic [4:0] expv;
        reset = 1'b1; enable = 1'b1; load = 1'b0;
        step();
        reset = 1'b0;
        for (int c = 0; c < 80; c++) begin
            settle();
            expv = {model_out(80, c), c == 79};
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("FAIL mid_load_cur c=%0d got=%b exp=%b", c, observed(), expv);
            end
            if (c == 10) begin
                div_in = DIV_W'(20); frac_in = FRAC_W'(0); load = 1'b1;
            end
            step();
            load = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 20; c++) begin
                settle();
                expv = {model_out(20, c), 1'b0};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL mid_load_new k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                step();
            end
        end
    endtask

    task automatic test_clamp();
        logic a0, a1;
        logic [4:0] expv;
        load_disabled(1, 0, a0, a1);
        checks++;
        if ({a0, a1} !== 2'b01) begin
            failures++;
            $display("FAIL clamp_load_ack got=%b exp=01", {a0, a1});
        end
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                settle();
                expv = {model_out(4, c), 1'b0};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL clamp_period k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                step();
            end
        end
    endtask

    task automatic test_overwrite_reset();
        logic [4:0] expv;
        reset = 1'b1; enable = 1'b1; load = 1'b0;
        step();
        reset = 1'b0;
        for (int c = 0; c < 80; c++) begin
            settle();
            expv = {model_out(80, c), c == 79};
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("FAIL overwrite_cur c=%0d got=%b exp=%b", c, observed(), expv);
            end
            if (c == 5)  begin div_in = DIV_W'(40); frac_in = FRAC_W'(0); load = 1'b1; end
            if (c == 30) begin div_in = DIV_W'(60); frac_in = FRAC_W'(0); load = 1'b1; end
            step();
            load = 1'b0;
        end
        for (int c = 0; c < 31; c++) begin
            settle();
            expv = {model_out(60, c), 1'b0};
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("FAIL overwrite_new c=%0d got=%b exp=%b", c, observed(), expv);
            end
            if (c == 10) begin div_in = DIV_W'(20); frac_in = FRAC_W'(0); load = 1'b1; end
            if (c == 30) reset = 1'b1;
            step();
            load = 1'b0;
        end
        settle();
        checks++;
        if (observed() !== 5'b00000) begin
            failures++;
            $display("FAIL reset_mid_period got=%b exp=%b", observed(), 5'b00000);
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 80; c++) begin
                settle();
                expv = {model_out(80, c), 1'b0};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL after_reset k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                step();
            end
        end
    endtask

    task automatic test_enable_drop();
        logic a0, a1;
        logic [4:0] expv;
        int p;
        reset = 1'b1; enable = 1'b1; load = 1'b0;
        step();
        reset = 1'b0;
        for (int c = 0; c <= 50; c++) begin
            settle();
            expv = {model_out(80, c), 1'b0};
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("FAIL drop_before c=%0d got=%b exp=%b", c, observed(), expv);
            end
            if (c == 50) enable = 1'b0;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (observed() !== 5'b00000) begin
                failures++;
                $display("FAIL drop_outputs i=%0d got=%b exp=%b", i, observed(), 5'b00000);
            end
            step();
        end
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 80; c++) begin
                settle();
                expv = {model_out(80, c), 1'b0};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL reenable k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                step();
            end
        end
        // Fractional case: drop during a stretched period, then restart from zero phase.
        load_disabled(10, 8, a0, a1);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p = period_len(10, 8, k);
            for (int c = 0; c < p; c++) begin
                settle();
                expv = {model_out(p, c), 1'b0};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL drop_frac_pre k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                if (k == 2 && c == 5) begin
                    enable = 1'b0;
                    step();
                    break;
                end
                step();
            end
        end
        step();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p = period_len(10, 8, k);
            for (int c = 0; c < p; c++) begin
                settle();
                expv = {model_out(p, c), 1'b0};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL drop_frac_post k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic a0, a1;
        logic [4:0] expv;
        load_disabled(20, 0, a0, a1);
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 20; c++) begin
                settle();
                expv = {model_out(20, c), (k == 1) && (c == 19)};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL boundary_load k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                if (k == 0 && c == 19) begin
                    div_in = DIV_W'(12); frac_in = FRAC_W'(0); load = 1'b1;
                end
                step();
                load = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 12; c++) begin
                settle();
                expv = {model_out(12, c), 1'b0};
                checks++;
                if (observed() !== expv) begin
                    failures++;
                    $display("FAIL boundary_new k=%0d c=%0d got=%b exp=%b", k, c, observed(), expv);
                end
                step();
            end
        end
    endtask

    task automatic test_random();
        logic a0, a1;
        logic [4:0] expv;
        int d, f, p;
        for (int it = 0; it < 6; it++) begin
            d = int'($urandom_range(40, 0));
            f = int'($urandom_range(15, 0));
            load_disabled(d, f, a0, a1);
            checks++;
            if ({a0, a1} !== 2'b01) begin
                failures++;
                $display("FAIL rand_load_ack it=%0d got=%b exp=01", it, {a0, a1});
            end
            enable = 1'b1;
            for (int k = 0; k < 18; k++) begin
                p = period_len(d, f, k);
                for (int c = 0; c < p; c++) begin
                    settle();
                    expv = {model_out(p, c), 1'b0};
                    checks++;
                    if (observed() !== expv) begin
                        failures++;
                        $display("FAIL rand_period it=%0d d=%0d f=%0d k=%0d c=%0d got=%b exp=%b",
                                 it, d, f, k, c, observed(), expv);
                    end
                    step();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frac_dither();
        test_mid_load();
        test_clamp();
        test_overwrite_reset();
        test_enable_drop();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/baudrate_frac.md
Name: baudrate_frac

Overview:
- Runtime-programmable successor to the fixed-table baud generator; serves the DShot encoders, UART TX/RX and the PWM output stage.
- The divisor is a register loaded through a load/ack handshake, not a compile-time lookup.
- It has a fractional part, so the average period is div + frac/2^FRAC_W clocks, dithered first-order.
- Emits a period tick, half-period and quarter-period phase levels, and a mid-period strobe for receiver sampling.

Parameters:
- DIV_W, 24, width of the integer divisor and period counter.
- FRAC_W, 4, width of the fractional divisor and phase accumulator.
- DEFAULT_DIV, 80, integer divisor after reset (150 kbaud at 12 MHz).
- DEFAULT_FRAC, 0, fractional divisor after reset.

Ports:
- clk_in  in  1  system clock (12 MHz nominal).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run when high; when low, counter, accumulator and outputs are held at 0.
- div_in  in  DIV_W  requested integer divisor.
- frac_in  in  FRAC_W  requested fractional divisor, in units of 1/2^FRAC_W clock.
- load  in  1  single-cycle request to capture div_in/frac_in.
- load_ack  out  1  one-cycle pulse on the cycle the captured values become active.
- clk_out  out  1  one-cycle pulse on the last cycle of each period.
- half_clk_out  out  1  high during the second half of each period.
- quarter_clk_out  out  1  square wave at twice the period rate.
- mid_strobe  out  1  one-cycle pulse at the period midpoint.

Behaviour:
- Clocking and reset: one clock, clk_in; reset is synchronous and active-high.
- Registered state: cnt[DIV_W], acc[FRAC_W], active div/frac, pending div/frac, pend flag, ext flag.
- Reset values: cnt=0, acc=0, active div=DEFAULT_DIV, active frac=DEFAULT_FRAC, pend=0, ext=0; all outputs 0.
- Clamping: any div below 4 (captured or default) is treated as 4, so P/4 >= 1.
- Period length: P = div + ext.
- Counting: while enable is high, cnt increments each cycle. At cnt==P-1, cnt <= 0 and {carry, acc} <= acc + frac; ext <= carry, so the next period is one clock longer.
- Output decode: combinational from the registers, all forced to 0 when enable is low.
  - clk_out = (cnt==P-1).
  - mid_strobe = (cnt==P>>1).
  - half_clk_out = (cnt >= P>>1).
  - quarter_clk_out = (P>>2 <= cnt < P>>1) or (cnt >= (P>>1)+(P>>2)).
- Load handshake:
  - load high captures div_in/frac_in into the pending registers and sets pend.
  - A later load before apply overwrites the pending values; there is no queue.
  - Apply point: the first cycle with pend=1 that is either a boundary (clk_out=1) or has enable low. On that cycle the pending values are written to active, pend clears and load_ack=1.
  - With enable high, the new values govern the period starting on the next cycle. The in-progress period is never truncated.
  - load on the same cycle as a boundary: the values are captured that cycle and applied at the following boundary. The exception is enable low, where they apply on the next cycle.
  - load with enable low: load_ack fires one cycle later.
- Applying new values resets acc to 0 and ext to 0.
- enable falling: on the next cycle cnt=0, acc=0, ext=0. Active values are kept.
- enable rising: counting restarts from cnt=0, and the first clk_out comes P cycles later.
- reset mid-period or mid-handshake discards pending values, restores defaults and emits no load_ack.
- Counter arithmetic is unsigned DIV_W bits. div_in = 2^DIV_W-1 with ext=1 needs DIV_W+1 bits, so P uses a DIV_W+1-bit compare.

Decomposition:
- Shared package baud_pkg holds:
  - DIV_MIN=4.
  - 12 MHz divisor constants: 20, 40, 80, 104, 208, 313, 625, 1250, 2500, 5000, 10000, 12000, 20000, 40000, 240000, 2400000.
  - Function baud_div(clk_hz, baud) returning the integer and FRAC_W fractional parts.
- One natural sub-module: baud_phase_decode. It takes cnt, P and enable and produces clk_out, mid_strobe, half_clk_out and quarter_clk_out; the main block keeps the counter, accumulator and handshake.

Test Plan:
- Reset defaults, enable=1: clk_out every 80 cycles; half_clk_out high at cnt 40..79; quarter_clk_out high at 20..39 and 60..79; mid_strobe at cnt 40; no load_ack.
- Fractional dithering: load div=104, frac=3 (FRAC_W=4) -> over 16 consecutive periods exactly 3 last 105 cycles, total 1667 cycles, and the pattern repeats.
- Mid-period load: with enable=1, pulse load div=20 at cnt=10 of an 80-cycle period -> the current period still ends at cycle 80; load_ack with that clk_out; the next period is 20 cycles.
- Load while disabled, then div clamp: enable=0, load div=1 -> load_ack next cycle; after enable=1, clk_out every 4 cycles and quarter_clk_out toggles every cycle.
- Overwrite, then reset: two loads (div=40 then div=60) within one period -> a single load_ack, next period 60. Assert reset at cnt=30 -> all outputs 0, the next period is 80 cycles, pending value lost.
- Enable drop: deassert enable at cnt=50 -> outputs 0 next cycle; on re-enable, first clk_out after exactly P cycles with acc restarted from 0.
